// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: gate FSM state type and a width-parameterised saturating increment
package freq_meter_pkg;
  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] mx;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= mx) ? mx : v + 64'd1;
  endfunction
endpackage

// File: rtl/edge_sync.sv
// edge_sync: 2-FF synchroniser plus registered rising-edge strobe (clock, resetn, async_in -> pulse)
module edge_sync (
  input  logic clock,
  input  logic resetn,
  input  logic async_in,
  output logic pulse
);
  logic s0, s1, prev;
  always_ff @(posedge clock)
    if (!resetn) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      prev <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s0 <= async_in;
      s1 <= s0;
      prev <= s1;
      pulse <= s1 & ~prev;
    end
endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated edge count and per-cycle period of sig_in vs clock (clock, resetn, sig_in, enable -> edge_pulse, freq_out/valid, overflow, period_out/valid)
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             sig_in,
  input  logic             enable,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  state_t state;
  logic [GW-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_cnt, p_cnt, edge_inc, p_inc, edge_next;
  logic armed, active;
  edge_sync u_sync (
    .clock(clock),
    .resetn(resetn),
    .async_in(sig_in),
    .pulse(edge_pulse)
  );
  always_comb begin
    edge_inc = CNT_W'(sat_inc(64'(edge_cnt), CNT_W));
    p_inc = CNT_W'(sat_inc(64'(p_cnt), CNT_W));
    edge_next = edge_pulse ? edge_inc : edge_cnt;
    active = (state == COUNT) && enable;
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      state <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      p_cnt <= '0;
      armed <= 1'b0;
      freq_out <= '0;
      freq_valid <= 1'b0;
      overflow <= 1'b0;
      period_out <= '0;
      period_valid <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      period_valid <= 1'b0;
      p_cnt <= edge_pulse ? CNT_W'(1) : p_inc;
      if (active && edge_pulse) begin
        armed <= 1'b1;
        if (armed) begin
          period_out <= p_cnt;
          period_valid <= 1'b1;
        end
      end
      if (state == IDLE) armed <= 1'b0;
      if (!active) begin
        state <= enable ? COUNT : IDLE;
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else if (gate_cnt == LAST) begin
        freq_out <= edge_next;
        overflow <= edge_next == CNT_MAX;
        freq_valid <= 1'b1;
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else begin
        gate_cnt <= gate_cnt + GW'(1);
        edge_cnt <= edge_next;
      end
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table, directed and random checks of two freq_meter widths against an edge-time reference model
module tb_freq_meter;
  localparam int G = 180;
  typedef struct {
    logic rstn;
    logic en;
    logic sig;
    logic ep;
  } vec_t;
  logic clock = 1'b0, resetn = 1'b0, enable = 1'b0, sig_in = 1'b0;
  logic ep_a, fv_a, ov_a, pv_a, ep_b, fv_b, ov_b, pv_b;
  logic [31:0] fo_a, po_a;
  logic [3:0] fo_b, po_b;
  int checks = 0, errors = 0, k = 0;
  bit m_ep, mode, have_last, m_fv, m_pv;
  int win_start, edges, last_edge;
  longint m_freq, m_per;
  bit hist[$];
  bit wave_on = 0, rnd_sig = 0;
  int hi = 5, lo = 5, ph = 0;
  freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut_a (
    .clock(clock), .resetn(resetn), .sig_in(sig_in), .enable(enable),
    .edge_pulse(ep_a), .freq_out(fo_a), .freq_valid(fv_a), .overflow(ov_a),
    .period_out(po_a), .period_valid(pv_a)
  );
  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
    .clock(clock), .resetn(resetn), .sig_in(sig_in), .enable(enable),
    .edge_pulse(ep_b), .freq_out(fo_b), .freq_valid(fv_b), .overflow(ov_b),
    .period_out(po_b), .period_valid(pv_b)
  );
  always #5 clock = ~clock;
  function automatic longint sat(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return v > mx ? mx : v;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
    end
  endtask
  task automatic model_edge();
    bit active;
    if (!resetn) begin
      mode = 0; have_last = 0; edges = 0; win_start = 0; last_edge = 0;
      m_freq = 0; m_per = 0; m_fv = 0; m_pv = 0; m_ep = 0;
      hist = '{0, 0, 0, 0};
    end else begin
      active = mode && enable;
      m_fv = 0;
      m_pv = 0;
      if (active && m_ep) begin
        if (have_last) begin
          m_per = k - last_edge;
          m_pv = 1;
        end
        have_last = 1;
        last_edge = k;
        edges++;
      end
      if (active && k - win_start == G - 1) begin
        m_freq = edges;
        m_fv = 1;
        edges = 0;
        win_start = k + 1;
      end
      if (!mode) have_last = 0;
      if (!mode && enable) begin
        mode = 1;
        win_start = k + 1;
        edges = 0;
      end else if (mode && !enable) mode = 0;
      hist.push_front(sig_in);
      void'(hist.pop_back());
      m_ep = hist[2] & ~hist[3];
    end
    k++;
  endtask
  task automatic compare();
    chk("edge_pulse_w32", ep_a, m_ep);
    chk("freq_valid_w32", fv_a, m_fv);
    chk("freq_out_w32", fo_a, sat(m_freq, 32));
    chk("overflow_w32", ov_a, m_freq >= sat(64'h7fffffff_ffffffff, 32));
    chk("period_valid_w32", pv_a, m_pv);
    chk("period_out_w32", po_a, sat(m_per, 32));
    chk("edge_pulse_w4", ep_b, m_ep);
    chk("freq_valid_w4", fv_b, m_fv);
    chk("freq_out_w4", fo_b, sat(m_freq, 4));
    chk("overflow_w4", ov_b, m_freq >= 15);
    chk("period_valid_w4", pv_b, m_pv);
    chk("period_out_w4", po_b, sat(m_per, 4));
  endtask
  task automatic step();
    if (rnd_sig) sig_in = 1'($urandom_range(0, 1));
    else if (wave_on) begin
      sig_in = (ph % (hi + lo)) < hi;
      ph++;
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask
  task automatic wait_fv(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!fv_a && n < budget);
    checks++;
    if (!fv_a) begin
      errors++;
      $display("FAIL freq_valid_timeout at cycle %0d: got none, expected within %0d cycles", k, budget);
    end
  endtask
  task automatic set_wave(input int h, input int l);
    hi = h;
    lo = l;
    ph = 0;
    wave_on = 1;
    rnd_sig = 0;
  endtask
  initial begin
    vec_t tv[11];
    int n, cnt;
    tv = '{'{0, 0, 1, 0}, '{0, 0, 1, 0}, '{1, 0, 1, 0}, '{1, 0, 1, 0}, '{1, 0, 1, 1},
           '{1, 0, 1, 0}, '{1, 0, 0, 0}, '{1, 0, 1, 0}, '{1, 0, 1, 0}, '{1, 0, 1, 1},
           '{0, 0, 1, 0}};
    foreach (tv[i]) begin
      resetn = tv[i].rstn;
      enable = tv[i].en;
      sig_in = tv[i].sig;
      step();
      chk("tbl_edge_pulse", ep_a, tv[i].ep);
    end
    chk("rst_freq_out", fo_a, 0);
    chk("rst_freq_valid", fv_a, 0);
    chk("rst_overflow", ov_a, 0);
    chk("rst_period_out", po_a, 0);
    chk("rst_period_valid", pv_a, 0);
    resetn = 1;
    enable = 1;
    set_wave(5, 5);
    for (int w = 0; w < 3; w++) begin
      wait_fv(400, n);
      if (w == 0) chk("first_fv_latency", n, G + 1);
      chk("p10_freq_w32", fo_a, 18);
      chk("p10_ovf_w32", ov_a, 0);
      chk("p10_freq_w4", fo_b, 15);
      chk("p10_ovf_w4", ov_b, 1);
      chk("p10_period", po_a, 10);
    end
    enable = 0;
    repeat (3) step();
    enable = 1;
    step();
    repeat (90) step();
    enable = 0;
    set_wave(3, 3);
    cnt = 0;
    repeat (300) begin
      step();
      cnt += int'(fv_a);
    end
    chk("dis_no_fv", cnt, 0);
    chk("dis_hold_freq", fo_a, 18);
    chk("dis_hold_period", po_a, 10);
    set_wave(5, 5);
    repeat (10) step();
    enable = 1;
    wait_fv(400, n);
    chk("reen_fv_latency", n, G + 1);
    chk("reen_freq", fo_a, 18);
    set_wave(9, 9);
    repeat (3) wait_fv(400, n);
    chk("p18_freq", fo_a, 10);
    chk("p18_period", po_a, 18);
    set_wave(2, 2);
    repeat (3) wait_fv(400, n);
    chk("p4_freq_w4", fo_b, 15);
    chk("p4_ovf_w4", ov_b, 1);
    chk("p4_freq_w32", fo_a, 45);
    set_wave(10, 10);
    repeat (3) wait_fv(400, n);
    chk("p20_freq_w4", fo_b, 9);
    chk("p20_ovf_w4", ov_b, 0);
    chk("p20_period_w4", po_b, 15);
    chk("p20_period_w32", po_a, 20);
    wave_on = 0;
    sig_in = 0;
    enable = 0;
    repeat (5) step();
    enable = 1;
    step();
    for (int i = 1; i < G - 3; i++) step();
    sig_in = 1;
    wait_fv(10, n);
    chk("term_latency", n, 4);
    chk("term_edge_in_ending_window", fo_a, 1);
    wait_fv(200, n);
    chk("term_next_window_len", n, G);
    chk("term_next_window_empty", fo_a, 0);
    set_wave(5, 5);
    repeat (70) step();
    resetn = 0;
    step();
    chk("mid_rst_freq_out", fo_a, 0);
    chk("mid_rst_overflow", ov_a, 0);
    chk("mid_rst_period_out", po_a, 0);
    chk("mid_rst_edge_pulse", ep_a, 0);
    chk("mid_rst_freq_valid", fv_a, 0);
    chk("mid_rst_period_valid", pv_a, 0);
    resetn = 1;
    wait_fv(400, n);
    chk("mid_rst_restart_latency", n, G + 1);
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        wave_on = 0;
        rnd_sig = 1;
      end else set_wave(int'($urandom_range(2, 12)), int'($urandom_range(2, 12)));
      enable = $urandom_range(0, 99) < 85;
      if ($urandom_range(0, 19) == 0) begin
        resetn = 0;
        step();
        resetn = 1;
      end
      repeat ($urandom_range(20, 400)) step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
# freq_meter

Measures an incoming square wave, such as a divided clock or an external pin, against the 100 MHz system clock. Each gate window it reports the number of rising edges counted, and for every cycle of the input it reports the period in system-clock cycles. It is used to check divider outputs on hardware and to read frequencies off external sources. It also gives downstream logic a synchronised single-cycle strobe on each rising edge.

## Interface
- `GATE_CYCLES`, 100_000_000: gate window length in `clock` cycles (1 s at 100 MHz); must be ≥ 2.
- `CNT_W`, 32: width of the edge and period counters and outputs.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `sig_in`  in  1  signal under measurement; asynchronous to `clock`.
- `enable`  in  1  1 = measure; 0 = idle and discard any partial window.
- `edge_pulse`  out  1  one-cycle strobe per synchronised rising edge of `sig_in`.
- `freq_out`  out  CNT_W  rising edges counted in the last completed window (saturating).
- `freq_valid`  out  1  one-cycle strobe: `freq_out` and `overflow` were updated this cycle.
- `overflow`  out  1  the last published window saturated.
- `period_out`  out  CNT_W  `clock` cycles between the last two rising edges (saturating).
- `period_valid`  out  1  one-cycle strobe: `period_out` was updated this cycle.

## Operation
- Front end:
  - `sig_in` goes through a 2-FF synchroniser (`s0`, `s1`) and then a history register `prev`.
  - `edge_pulse` is registered as `s1 & ~prev`. All counting uses `edge_pulse`.
- Gate FSM, states IDLE and COUNT:
  - IDLE: `gate_cnt` = 0 and `edge_cnt` = 0. Moves to COUNT on the first cycle `enable` = 1.
  - COUNT: `gate_cnt` increments every cycle. `edge_cnt` increments on each `edge_pulse` and saturates at 2^CNT_W−1.
  - The terminal cycle is `gate_cnt` == GATE_CYCLES−1. On it:
    - `freq_out` is loaded with `edge_cnt` plus that cycle's `edge_pulse`, saturated.
    - `overflow` is set if the count saturated, otherwise cleared.
    - `freq_valid` goes high on the next cycle.
    - Both counters restart at 0, so windows are gapless. An edge on the terminal cycle belongs to the ending window; an edge on the next cycle belongs to the new window.
  - `enable` = 0 in COUNT: go to IDLE, drop the partial counts, no `freq_valid`. `freq_out`, `overflow` and `period_out` keep their values.
- Period path:
  - `p_cnt` increments every cycle and saturates at 2^CNT_W−1.
  - On `edge_pulse`, `p_cnt` reloads to 1.
  - On every `edge_pulse` after the first one since enable, `period_out` ← `p_cnt` and `period_valid` pulses on the next cycle.
  - The first edge after enable, or after reset, only arms the path (`armed` flag).
  - Example: edges at cycles 10 and 18 give `period_out` = 8.
  - `armed` clears in IDLE.
- Reset (`resetn` = 0 on a clock edge):
  - Clears every register: outputs, counters, `armed`, synchroniser, and the FSM (to IDLE).
  - Applies even mid-window; the partial result is lost.

## Timing
- Reset value of every output is 0.
- `sig_in` first sampled high at edge E0 → `edge_pulse` high for the cycle after E2 (latency 3 edges).
- Inputs counted reliably must hold high ≥ 2 cycles and low ≥ 2 cycles. Maximum measurable rate is `clock`/4; faster inputs undercount, and that is not flagged.
- `freq_valid` is 1 cycle, every GATE_CYCLES cycles while enabled. The first one comes GATE_CYCLES+1 cycles after the cycle COUNT is entered.
- `period_valid` is 1 cycle, on the cycle after the `edge_pulse` that caused it.
- `freq_valid` and `period_valid` are independent and may assert in the same cycle.

## Structure
- Package `freq_meter_pkg`:
  - state enum `{IDLE, COUNT}`.
  - saturating-increment function, parameterised by width.
- Sub-module `edge_sync`: 2-FF synchroniser plus the registered rising-edge detector. It takes `clock` and `resetn`, and is reusable for buttons and other asynchronous inputs.
- Top level holds the FSM, the gate, edge and period counters, and the output registers. Target size is about 150–250 lines.

## Test plan
- GATE_CYCLES=180, `sig_in` period 10 (5 high, 5 low), `enable`=1 → every window `freq_out`=18, `overflow`=0; `period_out`=10 from the second edge on.
- GATE_CYCLES=180, `sig_in` toggling every 9 cycles (divider-style, period 18) → `freq_out`=10 and `period_out`=18.
- CNT_W=4, GATE_CYCLES=180, period 4 → `freq_out`=15, `overflow`=1; a later window at period 20 gives `freq_out`=9, `overflow`=0.
- Align an `edge_pulse` to the terminal cycle → it is counted in the ending window, not the next one; total over consecutive windows equals total edges.
- Deassert `enable` at `gate_cnt`=90 → no `freq_valid` and outputs held. Re-enable → first `freq_valid` 181 cycles later, and the first edge produces no `period_valid`.
- Pull `resetn` low for 1 cycle mid-window → every output 0 on the next cycle, FSM in IDLE, counting restarts from 0.
